tele_line_arbiter: RTL and testbench
====================================

Name: tele_line_arbiter

Overview:
- Shares one outgoing trunk line between N_PORTS handset FSMs; sequences dial, connect, release and timeout for the current owner.
- Round-robin grant among requesting ports; owns the dial-wait and call-duration counters for the trunk.
- Sits between the per-handset call FSMs and the single trunk interface.

Parameters:
- N_PORTS, 4, number of requesting handsets (2..8)
- DIAL_LIMIT, 5, max cycles in DIAL awaiting pickup
- CALL_LIMIT, 250, max cycles in CONNECTED
- CNT_W, 8, counter width; must satisfy 2^CNT_W > max(DIAL_LIMIT, CALL_LIMIT)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  N_PORTS  per-port dial request (valid contact + dial)
- release  in  N_PORTS  per-port end-call / abandon
- cancel  in  N_PORTS  per-port timeout acknowledge
- pickup  in  1  far end answered
- grant  out  N_PORTS  one-hot trunk owner, registered
- owner_id  out  $clog2(N_PORTS)  index of owner; 0 when idle
- in_call  out  1  CONNECTED state
- dial_timeout  out  1  TIMEOUT state entered from DIAL
- call_timeout  out  1  TIMEOUT state entered from CONNECTED
- busy  out  1  state != IDLE

Behaviour:
- All outputs registered (Moore). On reset: state IDLE, grant 0, owner_id 0, in_call/dial_timeout/call_timeout/busy 0, both counters 0, rr pointer 0. Reset mid-call drops grant immediately (async).
- States: IDLE, DIAL, CONNECTED, RELEASE, TIMEOUT.
- IDLE: if any req bit set, pick first requester searching from rr pointer upward with wrap (ptr, ptr+1, ..., N_PORTS-1, 0, ...); next cycle state=DIAL, grant one-hot = winner, owner_id = winner. Grant latency: 1 cycle after req sampled.
- DIAL: dial_cnt cleared on entry, +1 each DIAL cycle. Priority per cycle: release[owner] or req[owner]==0 -> RELEASE; else pickup -> CONNECTED; else dial_cnt==DIAL_LIMIT-1 -> TIMEOUT (dial_timeout=1). DIAL therefore lasts at most DIAL_LIMIT cycles. Pickup on the limit cycle -> CONNECTED.
- CONNECTED: in_call=1; call_cnt cleared on entry, +1 per cycle. release[owner] -> RELEASE; else call_cnt==CALL_LIMIT-1 -> TIMEOUT (call_timeout=1). Release on the limit cycle wins (RELEASE, no timeout). req drop ignored here.
- RELEASE: exactly 1 cycle; grant=0, busy=1; rr pointer <= (owner+1) mod N_PORTS; -> IDLE.
- TIMEOUT: grant held, busy=1, timeout flag held until cancel[owner]; then rr pointer <= (owner+1) mod N_PORTS, -> IDLE.
- Inputs from non-owner ports (release, cancel) ignored while busy; their req stays pending, no queueing beyond level-held req.
- Counters saturate never (bounded by limits); they are cleared in IDLE, RELEASE, TIMEOUT.
- grant always zero or one-hot; at most one of in_call/dial_timeout/call_timeout set.

Optional Feature:
- TELE_EMERG_PRIO_EN: defined -> port 0 is emergency: in IDLE req[0] wins regardless of rr pointer, and CALL_LIMIT timeout is disabled for owner 0 (CONNECTED held until release[0]). Undefined -> pure round-robin, all ports time out identically.

Test Plan:
- Reset then req=4'b0010 -> grant=4'b0010, owner_id=1 one cycle later; pickup at 2nd DIAL cycle -> in_call=1 next cycle.
- req[2] held, no pickup -> dial_timeout=1 exactly 5 cycles after grant; cancel[1] ignored; cancel[2] -> IDLE, busy=0 next cycle.
- Owner 0 connected 249 cycles, release[0] on the cycle call_cnt==249 -> RELEASE then IDLE, call_timeout never 1; with no release -> call_timeout=1 after 250 in_call cycles.
- req=4'b1111 continuously, each call released after pickup -> grants in order 0,1,2,3,0 (non-emergency build).
- Assert reset while in_call=1 -> grant, in_call, busy go 0 without clock edge; after deassert, pending req re-arbitrated from port 0.
- TELE_EMERG_PRIO_EN build, rr pointer=2, req=4'b0101 -> grant=4'b0001; connected 300 cycles with no timeout.

Source files
------------

// File: rtl/tele_line_arbiter_if.sv
// Handset-side request/response bundle for the trunk line arbiter.
// i_* are driven toward the arbiter and o_* are driven by the arbiter.
interface tele_line_arbiter_if #(
    parameter int N_PORTS = 4,
    parameter int ID_W    = $clog2(N_PORTS)
);
    logic [N_PORTS-1:0] i_req;
    logic [N_PORTS-1:0] i_release;
    logic [N_PORTS-1:0] i_cancel;
    logic               i_pickup;
    logic [N_PORTS-1:0] o_grant;
    logic [ID_W-1:0]    o_owner_id;
    logic               o_in_call;
    logic               o_dial_timeout;
    logic               o_call_timeout;
    logic               o_busy;

    modport master (
        output i_req, i_release, i_cancel, i_pickup,
        input  o_grant, o_owner_id, o_in_call, o_dial_timeout, o_call_timeout, o_busy
    );

    modport slave (
        input  i_req, i_release, i_cancel, i_pickup,
        output o_grant, o_owner_id, o_in_call, o_dial_timeout, o_call_timeout, o_busy
    );
endinterface

// File: rtl/tele_line_arbiter.sv
// Round-robin trunk arbiter with dial/call sequencing; grant 1 cycle after req, all outputs registered, no backpressure.
// TELE_EMERG_PRIO_EN: port 0 always wins arbitration and is exempt from the call-duration timeout.
module tele_line_arbiter #(
    parameter int N_PORTS    = 4,
    parameter int DIAL_LIMIT = 5,
    parameter int CALL_LIMIT = 250,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic reset,
    tele_line_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_PORTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIAL,
        S_CONN,
        S_REL,
        S_TMO
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [ID_W-1:0]    r_owner, w_owner_nxt;
    logic [ID_W-1:0]    r_rr_ptr, w_rr_nxt;
    logic [CNT_W-1:0]   r_dial_cnt, w_dial_nxt;
    logic [CNT_W-1:0]   r_call_cnt, w_call_nxt;
    logic [N_PORTS-1:0] r_grant, w_grant_nxt;
    logic [ID_W-1:0]    r_owner_id, w_owner_id_nxt;
    logic               r_in_call, w_in_call_nxt;
    logic               r_dial_to, w_dial_to_nxt;
    logic               r_call_to, w_call_to_nxt;
    logic               r_busy, w_busy_nxt;

    logic               w_found;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W-1:0]    w_cand;
    logic               w_call_limited;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        return (32'(v) == N_PORTS - 1) ? '0 : v + 1'b1;
    endfunction

`ifdef TELE_EMERG_PRIO_EN
    assign w_call_limited = (r_owner != '0);
`else
    assign w_call_limited = 1'b1;
`endif

    // Search upward from the rr pointer with wrap; first hit wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = r_rr_ptr;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!w_found && bus.i_req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
            w_cand = wrap_inc(w_cand);
        end
`ifdef TELE_EMERG_PRIO_EN
        if (bus.i_req[0]) begin
            w_found  = 1'b1;
            w_winner = '0;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_DIAL;
                    w_owner_nxt = w_winner;
                end
            end
            S_DIAL: begin
                if (bus.i_release[r_owner] || !bus.i_req[r_owner]) begin
                    w_state_nxt = S_REL;
                end else if (bus.i_pickup) begin
                    w_state_nxt = S_CONN;
                end else if (r_dial_cnt == CNT_W'(DIAL_LIMIT - 1)) begin
                    w_state_nxt = S_TMO;
                end
            end
            S_CONN: begin
                if (bus.i_release[r_owner]) begin
                    w_state_nxt = S_REL;
                end else if (w_call_limited && r_call_cnt == CNT_W'(CALL_LIMIT - 1)) begin
                    w_state_nxt = S_TMO;
                end
            end
            S_REL: begin
                w_state_nxt = S_IDLE;
                w_rr_nxt    = wrap_inc(r_owner);
            end
            S_TMO: begin
                if (bus.i_cancel[r_owner]) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = wrap_inc(r_owner);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters run only while staying in their state; any exit clears them.
    always_comb begin
        w_dial_nxt = '0;
        w_call_nxt = '0;
        if (r_state == S_DIAL && w_state_nxt == S_DIAL) begin
            w_dial_nxt = r_dial_cnt + 1'b1;
        end
        if (r_state == S_CONN && w_state_nxt == S_CONN) begin
            w_call_nxt = (r_call_cnt == CNT_W'(CALL_LIMIT - 1)) ? r_call_cnt : r_call_cnt + 1'b1;
        end
    end

    // Moore outputs computed from the next state and registered with it.
    always_comb begin
        w_grant_nxt    = '0;
        w_owner_id_nxt = '0;
        w_in_call_nxt  = 1'b0;
        w_dial_to_nxt  = 1'b0;
        w_call_to_nxt  = 1'b0;
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        if (w_state_nxt != S_IDLE) begin
            w_owner_id_nxt = w_owner_nxt;
        end
        if (w_state_nxt == S_DIAL || w_state_nxt == S_CONN || w_state_nxt == S_TMO) begin
            w_grant_nxt = N_PORTS'(1) << w_owner_nxt;
        end
        if (w_state_nxt == S_CONN) begin
            w_in_call_nxt = 1'b1;
        end
        if (w_state_nxt == S_TMO) begin
            w_dial_to_nxt = (r_state == S_DIAL) || r_dial_to;
            w_call_to_nxt = (r_state == S_CONN) || r_call_to;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_dial_cnt <= '0;
            r_call_cnt <= '0;
            r_grant    <= '0;
            r_owner_id <= '0;
            r_in_call  <= 1'b0;
            r_dial_to  <= 1'b0;
            r_call_to  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_dial_cnt <= w_dial_nxt;
            r_call_cnt <= w_call_nxt;
            r_grant    <= w_grant_nxt;
            r_owner_id <= w_owner_id_nxt;
            r_in_call  <= w_in_call_nxt;
            r_dial_to  <= w_dial_to_nxt;
            r_call_to  <= w_call_to_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign bus.o_grant        = r_grant;
    assign bus.o_owner_id     = r_owner_id;
    assign bus.o_in_call      = r_in_call;
    assign bus.o_dial_timeout = r_dial_to;
    assign bus.o_call_timeout = r_call_to;
    assign bus.o_busy         = r_busy;
endmodule

// File: tb/tb_tele_line_arbiter.sv
// Bench for tele_line_arbiter: per-cycle comparison against a call-phase model plus directed literal checks.
module tb_tele_line_arbiter;
    localparam int N          = 4;
    localparam int DIAL_LIMIT = 5;
    localparam int CALL_LIMIT = 250;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    tele_line_arbiter_if #(.N_PORTS(N)) ifc ();

    tele_line_arbiter #(
        .N_PORTS(N), .DIAL_LIMIT(DIAL_LIMIT), .CALL_LIMIT(CALL_LIMIT), .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which call phase the trunk is in, who holds it, and how long the phase has lasted.
    localparam int P_IDLE = 0, P_DIAL = 1, P_TALK = 2, P_REL = 3, P_TMO = 4;
    int m_phase, m_owner, m_age, m_rr, m_tkind;

    function automatic int pick();
`ifdef TELE_EMERG_PRIO_EN
        if (ifc.i_req[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (ifc.i_req[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit call_limited(input int who);
`ifdef TELE_EMERG_PRIO_EN
        return who != 0;
`else
        return who >= 0;
`endif
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_owner = 0; m_age = 0; m_rr = 0; m_tkind = 0;
    endtask

    task automatic model_step();
        int w;
        case (m_phase)
            P_IDLE: begin
                w = pick();
                if (w >= 0) begin m_owner = w; m_phase = P_DIAL; m_age = 1; end
            end
            P_DIAL: begin
                if (ifc.i_release[m_owner] || !ifc.i_req[m_owner]) m_phase = P_REL;
                else if (ifc.i_pickup) begin m_phase = P_TALK; m_age = 1; end
                else if (m_age >= DIAL_LIMIT) begin m_phase = P_TMO; m_tkind = 1; end
                else m_age++;
            end
            P_TALK: begin
                if (ifc.i_release[m_owner]) m_phase = P_REL;
                else if (call_limited(m_owner) && m_age >= CALL_LIMIT) begin m_phase = P_TMO; m_tkind = 2; end
                else m_age++;
            end
            P_REL: begin
                m_rr = (m_owner + 1) % N; m_phase = P_IDLE;
            end
            default: begin
                if (ifc.i_cancel[m_owner]) begin
                    m_rr = (m_owner + 1) % N; m_phase = P_IDLE; m_tkind = 0;
                end
            end
        endcase
    endtask

    function automatic logic [31:0] exp_grant();
        if (m_phase == P_DIAL || m_phase == P_TALK || m_phase == P_TMO) return 32'(1) << m_owner;
        return 32'd0;
    endfunction

    always @(posedge reset) model_reset();

    always @(posedge clk) begin
        if (reset) model_reset();
        else model_step();
        #1;
        chk("grant", 32'(ifc.o_grant), exp_grant());
        chk("owner_id", 32'(ifc.o_owner_id), (m_phase == P_IDLE) ? 32'd0 : 32'(m_owner));
        chk("in_call", 32'(ifc.o_in_call), 32'(m_phase == P_TALK));
        chk("dial_timeout", 32'(ifc.o_dial_timeout), 32'(m_phase == P_TMO && m_tkind == 1));
        chk("call_timeout", 32'(ifc.o_call_timeout), 32'(m_phase == P_TMO && m_tkind == 2));
        chk("busy", 32'(ifc.o_busy), 32'(m_phase != P_IDLE));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int exp_order [5];
        model_reset();
        reset = 1'b1;
        ifc.i_req = '0; ifc.i_release = '0; ifc.i_cancel = '0; ifc.i_pickup = 1'b0;
        tick(2);
        chk("rst_grant", 32'(ifc.o_grant), 32'd0);
        chk("rst_busy", 32'(ifc.o_busy), 32'd0);
        chk("rst_owner", 32'(ifc.o_owner_id), 32'd0);
        reset = 1'b0;
        tick(1);

        // Port 1 dials, answered on its second DIAL cycle.
        ifc.i_req = 4'b0010;
        tick(1);
        chk("t1_grant", 32'(ifc.o_grant), 32'h2);
        chk("t1_owner", 32'(ifc.o_owner_id), 32'd1);
        tick(1);
        ifc.i_pickup = 1'b1;
        tick(1);
        ifc.i_pickup = 1'b0;
        chk("t1_in_call", 32'(ifc.o_in_call), 32'd1);
        ifc.i_release = 4'b0010;
        tick(1);
        ifc.i_release = '0; ifc.i_req = '0;
        chk("t1_rel_grant", 32'(ifc.o_grant), 32'd0);
        chk("t1_rel_busy", 32'(ifc.o_busy), 32'd1);
        tick(1);
        chk("t1_idle_busy", 32'(ifc.o_busy), 32'd0);

        // Port 2 dials with no answer; times out 5 cycles after grant.
        ifc.i_req = 4'b0100;
        tick(1);
        chk("t2_grant", 32'(ifc.o_grant), 32'h4);
        tick(4);
        chk("t2_dto_early", 32'(ifc.o_dial_timeout), 32'd0);
        tick(1);
        chk("t2_dto", 32'(ifc.o_dial_timeout), 32'd1);
        ifc.i_cancel = 4'b0010;
        tick(1);
        chk("t2_foreign_cancel", 32'(ifc.o_dial_timeout), 32'd1);
        chk("t2_foreign_busy", 32'(ifc.o_busy), 32'd1);
        ifc.i_cancel = 4'b0100; ifc.i_req = '0;
        tick(1);
        ifc.i_cancel = '0;
        chk("t2_cancel_busy", 32'(ifc.o_busy), 32'd0);

        // Port 0 released exactly on the last allowed CONNECTED cycle.
        ifc.i_req = 4'b0001;
        tick(1);
        chk("t3_grant", 32'(ifc.o_grant), 32'h1);
        ifc.i_pickup = 1'b1;
        tick(1);
        ifc.i_pickup = 1'b0;
        tick(CALL_LIMIT - 1);
        chk("t3_last_cycle", 32'(ifc.o_in_call), 32'd1);
        ifc.i_release = 4'b0001;
        tick(1);
        ifc.i_release = '0; ifc.i_req = '0;
        chk("t3_rel_cto", 32'(ifc.o_call_timeout), 32'd0);
        chk("t3_rel_busy", 32'(ifc.o_busy), 32'd1);
        tick(1);

        // Port 0 again, never released.
        ifc.i_req = 4'b0001;
        tick(1);
        ifc.i_pickup = 1'b1;
        tick(1);
        ifc.i_pickup = 1'b0;
        tick(CALL_LIMIT - 1);
        chk("t3b_cto_early", 32'(ifc.o_call_timeout), 32'd0);
        tick(1);
`ifdef TELE_EMERG_PRIO_EN
        chk("t3b_emerg_hold", 32'(ifc.o_in_call), 32'd1);
        ifc.i_release = 4'b0001; ifc.i_req = '0;
        tick(1);
        ifc.i_release = '0;
`else
        chk("t3b_cto", 32'(ifc.o_call_timeout), 32'd1);
        chk("t3b_cto_grant", 32'(ifc.o_grant), 32'h1);
        ifc.i_cancel = 4'b0001; ifc.i_req = '0;
        tick(1);
        ifc.i_cancel = '0;
`endif
        tick(1);

        // Reset mid-call with requests still pending; re-arbitration restarts at port 0.
        ifc.i_req = 4'b1101;
        tick(1);
        chk("t5_grant", 32'(ifc.o_grant), 32'h4);
        ifc.i_pickup = 1'b1;
        tick(1);
        ifc.i_pickup = 1'b0;
        chk("t5_in_call", 32'(ifc.o_in_call), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_grant", 32'(ifc.o_grant), 32'd0);
        chk("t5_async_in_call", 32'(ifc.o_in_call), 32'd0);
        chk("t5_async_busy", 32'(ifc.o_busy), 32'd0);
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("t5_rearb", 32'(ifc.o_grant), 32'h1);
        ifc.i_req = '0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        tick(1);

        // All ports requesting continuously; each call answered then released.
`ifdef TELE_EMERG_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        ifc.i_req = 4'b1111;
        tick(1);
        for (int c = 0; c < 5; c++) begin
            chk("t4_rr_order", 32'(ifc.o_owner_id), 32'(exp_order[c]));
            ifc.i_pickup = 1'b1;
            tick(1);
            ifc.i_pickup = 1'b0;
            ifc.i_release = ifc.o_grant;
            tick(1);
            ifc.i_release = '0;
            tick(2);
        end
        ifc.i_req = '0;
        tick(3);

`ifdef TELE_EMERG_PRIO_EN
        // Move the rr pointer to 2, then port 0 must still win and never time out.
        ifc.i_req = 4'b0010;
        tick(1);
        ifc.i_release = 4'b0010;
        tick(1);
        ifc.i_release = '0; ifc.i_req = '0;
        tick(1);
        ifc.i_req = 4'b0101;
        tick(1);
        chk("e_grant", 32'(ifc.o_grant), 32'h1);
        ifc.i_pickup = 1'b1;
        tick(1);
        ifc.i_pickup = 1'b0;
        tick(300);
        chk("e_hold", 32'(ifc.o_in_call), 32'd1);
        ifc.i_release = 4'b0001; ifc.i_req = '0;
        tick(1);
        ifc.i_release = '0;
        tick(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
